// File: rtl/reduction_combiner.sv
// Collective reduction stage: gathers one flit from every port in the latched mask and
// emits a single combined flit (sum / unsigned max / unsigned min / OR), with timeout flush.
module reduction_combiner #(
    parameter int FAN_IN    = 6,
    parameter int FLIT_SIZE = 82,
    parameter int DATA_W    = 32,
    parameter int TIMEOUT   = 1024,
    parameter int TO_W      = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [FLIT_SIZE*FAN_IN-1:0] in,
    input  logic [FAN_IN-1:0]           in_valid,
    output logic [FAN_IN-1:0]           in_avail,
    input  logic [FAN_IN-1:0]           expect_mask,
    input  logic [1:0]                  op,
    output logic [FLIT_SIZE-1:0]        out,
    output logic                        out_valid,
    input  logic                        out_avail,
    output logic                        err_timeout
);
    localparam int              HDR_W   = FLIT_SIZE - DATA_W;
    localparam logic [1:0]      OP_SUM  = 2'd0;
    localparam logic [1:0]      OP_MAX  = 2'd1;
    localparam logic [1:0]      OP_MIN  = 2'd2;
    localparam logic [1:0]      OP_OR   = 2'd3;
    localparam bit              TO_EN   = (TIMEOUT != 0);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    typedef enum logic [0:0] {
        S_IDLE    = 1'b0,
        S_COLLECT = 1'b1
    } state_t;

    state_t               state_r, state_s;
    logic [FAN_IN-1:0]    full_r, mask_r, capture_s;
    logic [FLIT_SIZE-1:0] data_r [FAN_IN];
    logic [TO_W-1:0]      cnt_r;
    logic [FLIT_SIZE-1:0] out_r;
    logic                 out_valid_r, err_timeout_r;
    logic                 out_free_s, fire_s, flush_s;
    logic [DATA_W-1:0]    red_s;
    logic [HDR_W-1:0]     hdr_s;

    function automatic logic [DATA_W-1:0] op_identity(input logic [1:0] op_f);
        case (op_f)
            OP_MIN:  op_identity = {DATA_W{1'b1}};
            default: op_identity = {DATA_W{1'b0}};
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] op_combine(input logic [1:0]        op_f,
                                                     input logic [DATA_W-1:0] a,
                                                     input logic [DATA_W-1:0] b);
        case (op_f)
            OP_SUM:  op_combine = a + b;
            OP_MAX:  op_combine = (b > a) ? b : a;
            OP_MIN:  op_combine = (b < a) ? b : a;
            OP_OR:   op_combine = a | b;
            default: op_combine = a + b;
        endcase
    endfunction

    assign in_avail    = mask_r & ~full_r;
    assign capture_s   = in_valid & in_avail;
    assign out         = out_r;
    assign out_valid   = out_valid_r;
    assign err_timeout = err_timeout_r;

    // Fire and flush decisions; a complete slot set is never flushed, only held.
    always_comb begin
        out_free_s = ~out_valid_r | out_avail;
        fire_s     = (mask_r != {FAN_IN{1'b0}}) && (full_r == mask_r) && out_free_s;
        flush_s    = TO_EN && (state_r == S_COLLECT) && !fire_s &&
                     (full_r != mask_r) && (cnt_r == TO_LAST);
    end

    // Next-state logic for the collect FSM.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (capture_s != {FAN_IN{1'b0}}) state_s = S_COLLECT;
                else                             state_s = S_IDLE;
            end
            S_COLLECT: begin
                if (fire_s || flush_s) state_s = S_IDLE;
                else                   state_s = S_COLLECT;
            end
            default: state_s = S_IDLE;
        endcase
    end

    // Reduction over participating slots; header taken from the lowest participating port.
    always_comb begin
        red_s = op_identity(op);
        hdr_s = data_r[0][FLIT_SIZE-1:DATA_W];
        for (int i = 0; i < FAN_IN; i++) begin
            red_s = mask_r[i] ? op_combine(op, red_s, data_r[i][DATA_W-1:0]) : red_s;
        end
        for (int i = FAN_IN - 1; i >= 0; i--) begin
            hdr_s = mask_r[i] ? data_r[i][FLIT_SIZE-1:DATA_W] : hdr_s;
        end
    end

    // State register and mask latch; the mask is not reloaded on a capture edge so the
    // first captured slot always belongs to the mask that governs its collective.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= S_IDLE;
            mask_r  <= {FAN_IN{1'b0}};
        end else begin
            state_r <= state_s;
            if (state_r == S_IDLE && capture_s == {FAN_IN{1'b0}}) mask_r <= expect_mask;
        end
    end

    // Per-port holding slots.
    always_ff @(posedge clk) begin
        if (!rst) begin
            full_r <= {FAN_IN{1'b0}};
            for (int i = 0; i < FAN_IN; i++) data_r[i] <= {FLIT_SIZE{1'b0}};
        end else begin
            if (fire_s || flush_s) full_r <= {FAN_IN{1'b0}};
            else                   full_r <= full_r | capture_s;
            for (int i = 0; i < FAN_IN; i++) begin
                if (capture_s[i] && !flush_s) data_r[i] <= in[i*FLIT_SIZE +: FLIT_SIZE];
            end
        end
    end

    // Timeout counter: runs only while a collective is pending and not firing.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_r <= {TO_W{1'b0}};
        end else if (state_r == S_IDLE || fire_s || flush_s) begin
            cnt_r <= {TO_W{1'b0}};
        end else begin
            cnt_r <= cnt_r + TO_W'(1);
        end
    end

    // Output register and timeout pulse.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_r         <= {FLIT_SIZE{1'b0}};
            out_valid_r   <= 1'b0;
            err_timeout_r <= 1'b0;
        end else begin
            err_timeout_r <= flush_s;
            if (fire_s) begin
                out_r       <= {hdr_s, red_s};
                out_valid_r <= 1'b1;
            end else if (out_avail) begin
                out_valid_r <= 1'b0;
            end
        end
    end
endmodule

// File: doc/reduction_combiner.md
# reduction_combiner

Parametrised reduction unit for the MPI collective router. It collects one flit from each input port named in a per-collective participation mask and combines their payloads with a selectable operator: wrapping sum, unsigned max, unsigned min or bitwise OR. It emits one combined flit toward the eject/upstream port under a valid/avail handshake. A timeout flushes partial collectives. It sits between the per-port input queues and the router's output arbitration, replacing the fixed 6-input reduction stage.

## Interface
- FAN_IN, 6, number of contributing input ports (2..8)
- FLIT_SIZE, 82, flit width in bits
- DATA_W, 32, payload (operand) width; payload occupies flit bits [DATA_W-1:0], header occupies [FLIT_SIZE-1:DATA_W]
- TIMEOUT, 1024, cycles a partial collective may wait before flush; 0 disables
- TO_W, 16, width of timeout counter (TIMEOUT < 2^TO_W)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-low
- in  in  FLIT_SIZE*FAN_IN  input flits, port i at [i*FLIT_SIZE +: FLIT_SIZE]
- in_valid  in  FAN_IN  per-port flit valid
- in_avail  out  FAN_IN  per-port slot free and port participating
- expect_mask  in  FAN_IN  ports participating in the next collective
- op  in  2  operator: 0 sum, 1 max, 2 min, 3 or; sampled at fire
- out  out  FLIT_SIZE  combined flit (registered)
- out_valid  out  1  out holds a flit
- out_avail  in  1  downstream accepts out this cycle
- err_timeout  out  1  one-cycle pulse on partial-collective flush

## Operation
- Per-port one-deep holding slot: full[i], data[i]. Latched mask register mask_q.
- States: IDLE (no slot full), COLLECT (≥1 slot full).
- IDLE: mask_q <= expect_mask every cycle. Changes of expect_mask in COLLECT are ignored.
- in_avail[i] = mask_q[i] & ~full[i]. This is purely register-derived, with no combinational path from in_valid.
- Capture: in_valid[i] & in_avail[i] at an edge sets full[i] and stores the flit. in_valid on a non-avail port is ignored; no data is lost if the source holds the flit.
- Fire condition: mask_q != 0, full == mask_q, and output register free. Free means ~out_valid, or out_valid & out_avail in the same cycle.
- Fire actions:
  - out payload <= reduction over data[i] for i in mask_q, computed per op.
  - out header <= header of the lowest-index port in mask_q.
  - out_valid <= 1; all full cleared; state goes to IDLE.
- Arithmetic:
  - Sum is modulo 2^DATA_W; carries are discarded.
  - Max and min are unsigned.
  - A single-port mask passes that payload through unchanged.
- mask_q == 0: no ports available; the block stays in IDLE indefinitely.
- Output: out/out_valid hold stable until out_avail is high at an edge. If no new fire occurs, out_valid then clears; out retains its last value.
- Timeout counter:
  - Cleared in IDLE and on fire.
  - Increments each COLLECT cycle in which fire does not occur.
  - When it reaches TIMEOUT (TIMEOUT != 0): all full cleared, err_timeout pulses high for one cycle, state goes to IDLE, counter cleared.
  - A capture in the same cycle as the flush is discarded.
  - A pending out flit is unaffected.

## Timing
- Reset (rst==0 at edge) forces: full=0, mask_q=0, out=0, out_valid=0, err_timeout=0, counter=0. Consequently in_avail=0.
- First cycle after reset release: mask_q loads, so in_avail rises one cycle after release.
- Latency: last required capture at edge N gives fire eligibility in cycle N. out_valid is high after edge N+1, and in_avail for the freed ports is high after edge N+1.
- Back-to-back: with out_avail held high, one collective completes every 2 cycles minimum (capture edge, fire edge).
- Simultaneous drain and fire: the old flit is consumed and the new flit loaded on the same edge; out_valid stays high.
- Output blocked (out_valid & ~out_avail) with all slots full: the block holds and does not fire. The timeout counter keeps incrementing, but a full slot set never flushes; flush applies only when full != mask_q.
- Reset mid-collective discards all slots and any pending out flit.

## Test plan
- Sum, mask 6'b111111: port payloads 1,2,3,4,5,6 captured the same cycle, out_avail=1 -> out payload 21 and header of port 0, out_valid one cycle after capture; in_avail returns to 6'b111111.
- Wrap and operators, mask 6'b000101: payloads 0xFFFFFFFF and 0x00000002. op=0 -> 0x00000001; op=1 -> 0xFFFFFFFF; op=2 -> 0x00000002; op=3 -> 0xFFFFFFFF. Header comes from port 0.
- Staggered arrival with backpressure: mask 6'b110000, port 4 at cycle 0, port 5 at cycle 7, out_avail=0 for 5 cycles after fire -> out stable for those 5 cycles. The next collective does not fire until the drain, then fires on the drain edge with out_valid continuous.
- Timeout: TIMEOUT=8, mask 6'b000011, only port 0 sends -> err_timeout pulses exactly once, 8 COLLECT cycles after capture. No out_valid; in_avail[0] high again the next cycle.
- Mask latch: expect_mask changes from 6'b000011 to 6'b111111 during COLLECT -> ignored; fire after ports 0 and 1 only. The new mask is visible on in_avail only after return to IDLE.
- Reset: rst=0 for one edge mid-collective with out_valid=1 -> out_valid=0, out=0, in_avail=0 that cycle; in_avail equals expect_mask one cycle after release.
